proc_ctrl: RTL and testbench

Control sequencer for the 8-bit processor datapath. It decodes the 4-bit opcode and fcode returned by the datapath and drives every `CTRL_*` strobe. It also sequences run control (idle, init, run, halt) and stretches loads into two cycles by holding the PC. It keeps cycle and retired-instruction counters for the test harness.

---
 rtl/proc_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_proc_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl.sv
// Run-control sequencer and instruction decoder for the 8-bit processor datapath.
// Stretches LOAD into two cycles and keeps saturating cycle/retire counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, PC held, no strobes
// INIT    | one-cycle datapath START pulse, counters cleared on entry
// RUN     | one instruction decoded per cycle
// LOAD_WB | second LOAD cycle: memory data written back, PC released
// HALTED  | HALT or done_in seen; counters frozen, start re-runs
module proc_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             fcode,
    input  logic             done_in,
    output logic             dp_start,
    output logic             pc_hold,
    output logic             CTRL_branch_rel_nz,
    output logic             CTRL_branch_rel_z,
    output logic             CTRL_branch_abs,
    output logic             CTRL_reg_write_en,
    output logic             CTRL_reg_sel,
    output logic             CTRL_lut_in,
    output logic             CTRL_mem_to_reg,
    output logic             CTRL_alu_src,
    output logic             CTRL_alu_sc_in,
    output logic             CTRL_read_mem,
    output logic             CTRL_write_mem,
    output logic [2:0]       CTRL_alu_op,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_LOAD_WB = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_instr;
    logic             w_is_load;
    logic             w_is_halt;
    logic             w_cnt_clr;
    logic             w_cycle_inc;
    logic             w_instr_inc;

    assign w_is_load = (opcode == 4'd9);
    assign w_is_halt = (opcode == 4'd15) && fcode;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_INIT;
            S_INIT:    w_next = S_RUN;
            S_RUN: begin
                // done_in wins over LOAD: the writeback is abandoned
                if (w_is_halt || done_in) begin
                    w_next = S_HALTED;
                end else if (w_is_load) begin
                    w_next = S_LOAD_WB;
                end
            end
            S_LOAD_WB: w_next = S_RUN;
            S_HALTED:  if (start) w_next = S_INIT;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        dp_start           = 1'b0;
        pc_hold            = 1'b1;
        CTRL_branch_rel_nz = 1'b0;
        CTRL_branch_rel_z  = 1'b0;
        CTRL_branch_abs    = 1'b0;
        CTRL_reg_write_en  = 1'b0;
        CTRL_reg_sel       = 1'b0;
        CTRL_lut_in        = 1'b0;
        CTRL_mem_to_reg    = 1'b0;
        CTRL_alu_src       = 1'b0;
        CTRL_alu_sc_in     = 1'b0;
        CTRL_read_mem      = 1'b0;
        CTRL_write_mem     = 1'b0;
        CTRL_alu_op        = 3'd0;
        busy               = 1'b0;
        halted             = 1'b0;
        case (r_state)
            S_INIT: begin
                dp_start = 1'b1;
                pc_hold  = 1'b0;
                busy     = 1'b1;
            end
            S_RUN: begin
                busy    = 1'b1;
                pc_hold = 1'b0;
                if (!opcode[3]) begin
                    CTRL_alu_op       = opcode[2:0];
                    CTRL_reg_write_en = 1'b1;
                    CTRL_alu_sc_in    = (opcode[2:0] == 3'd1);
                end else begin
                    case (opcode[2:0])
                        3'd0: begin
                            CTRL_alu_src      = 1'b1;
                            CTRL_reg_write_en = 1'b1;
                        end
                        3'd1: begin
                            CTRL_read_mem = 1'b1;
                            pc_hold       = 1'b1;
                        end
                        3'd2: CTRL_write_mem     = 1'b1;
                        3'd3: CTRL_branch_rel_z  = 1'b1;
                        3'd4: CTRL_branch_rel_nz = 1'b1;
                        3'd5: CTRL_branch_abs    = 1'b1;
                        3'd6: begin
                            CTRL_reg_sel      = 1'b1;
                            CTRL_reg_write_en = 1'b1;
                            CTRL_branch_abs   = 1'b1;
                        end
                        default: begin
                            if (fcode) begin
                                pc_hold = 1'b1;
                            end else begin
                                CTRL_lut_in     = 1'b1;
                                CTRL_branch_abs = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_LOAD_WB: begin
                busy              = 1'b1;
                pc_hold           = 1'b0;
                CTRL_read_mem     = 1'b1;
                CTRL_mem_to_reg   = 1'b1;
                CTRL_reg_write_en = 1'b1;
            end
            S_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    assign w_cnt_clr   = ((r_state == S_IDLE) || (r_state == S_HALTED)) && start;
    assign w_cycle_inc = (r_state == S_RUN) || (r_state == S_LOAD_WB);
    assign w_instr_inc = (r_state == S_LOAD_WB) ||
                         ((r_state == S_RUN) && !w_is_load && !w_is_halt);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_cycle <= '0;
            r_instr <= '0;
        end else if (w_cnt_clr) begin
            r_cycle <= '0;
            r_instr <= '0;
        end else begin
            if (w_cycle_inc && (r_cycle != '1)) r_cycle <= r_cycle + 1'b1;
            if (w_instr_inc && (r_instr != '1)) r_instr <= r_instr + 1'b1;
        end
    end

    assign cycle_count = r_cycle;
    assign instr_count = r_instr;

endmodule

// File: tb/tb_proc_ctrl.sv
// Randomized bench for proc_ctrl: a phase-level reference model predicts every strobe
// and both counters; a second instance with 4-bit counters exercises saturation.
module tb_proc_ctrl;

    localparam int P_IDLE = 0, P_INIT = 1, P_RUN = 2, P_LOAD = 3, P_HALTED = 4;
    localparam logic [17:0] RST_OBS = 18'h10000;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic fcode = 1'b0;
    logic done_in = 1'b0;

    logic dp_start, pc_hold, bnz, bz, babs, rwe, rsel, lut, m2r, asrc, sc, rd, wr, busy, halted;
    logic [2:0] aop;
    logic [15:0] cyc16, ins16;
    logic dp_start4, pc_hold4, bnz4, bz4, babs4, rwe4, rsel4, lut4, m2r4, asrc4, sc4, rd4, wr4, busy4, halted4;
    logic [2:0] aop4;
    logic [3:0] cyc4, ins4;

    int n_cmp = 0;
    int n_fail = 0;

    int m_ph = P_IDLE;
    int m_cyc = 0;
    int m_ins = 0;

    proc_ctrl #(.CNT_W(16)) dut (
        .CLK(CLK), .reset(reset), .start(start), .opcode(opcode), .fcode(fcode), .done_in(done_in),
        .dp_start(dp_start), .pc_hold(pc_hold),
        .CTRL_branch_rel_nz(bnz), .CTRL_branch_rel_z(bz), .CTRL_branch_abs(babs),
        .CTRL_reg_write_en(rwe), .CTRL_reg_sel(rsel), .CTRL_lut_in(lut),
        .CTRL_mem_to_reg(m2r), .CTRL_alu_src(asrc), .CTRL_alu_sc_in(sc),
        .CTRL_read_mem(rd), .CTRL_write_mem(wr), .CTRL_alu_op(aop),
        .busy(busy), .halted(halted), .cycle_count(cyc16), .instr_count(ins16)
    );

    proc_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .reset(reset), .start(start), .opcode(opcode), .fcode(fcode), .done_in(done_in),
        .dp_start(dp_start4), .pc_hold(pc_hold4),
        .CTRL_branch_rel_nz(bnz4), .CTRL_branch_rel_z(bz4), .CTRL_branch_abs(babs4),
        .CTRL_reg_write_en(rwe4), .CTRL_reg_sel(rsel4), .CTRL_lut_in(lut4),
        .CTRL_mem_to_reg(m2r4), .CTRL_alu_src(asrc4), .CTRL_alu_sc_in(sc4),
        .CTRL_read_mem(rd4), .CTRL_write_mem(wr4), .CTRL_alu_op(aop4),
        .busy(busy4), .halted(halted4), .cycle_count(cyc4), .instr_count(ins4)
    );

    always #5 CLK = ~CLK;

    logic [17:0] obs, obs4, exp_o;
    logic [15:0] exp_cyc16, exp_ins16;
    logic [3:0]  exp_cyc4, exp_ins4;

    assign obs  = {dp_start, pc_hold, bnz, bz, babs, rwe, rsel, lut, m2r, asrc, sc, rd, wr, aop, busy, halted};
    assign obs4 = {dp_start4, pc_hold4, bnz4, bz4, babs4, rwe4, rsel4, lut4, m2r4, asrc4, sc4, rd4, wr4, aop4,
                   busy4, halted4};

    // Expected strobes straight from the decode table, bit order matching obs
    function automatic logic [17:0] exp_ctrl(input int ph, input logic [3:0] op, input logic fc);
        logic dps = 0, pch = 1, xbnz = 0, xbz = 0, xbabs = 0, xrwe = 0, xrsel = 0, xlut = 0;
        logic xm2r = 0, xasrc = 0, xsc = 0, xrd = 0, xwr = 0, bsy = 0, hlt = 0;
        logic [2:0] xaop = 3'd0;
        case (ph)
            P_INIT:   begin dps = 1; pch = 0; bsy = 1; end
            P_HALTED: hlt = 1;
            P_LOAD:   begin xrd = 1; xm2r = 1; xrwe = 1; pch = 0; bsy = 1; end
            P_RUN: begin
                bsy = 1;
                pch = 0;
                if (op < 8) begin
                    xaop = op[2:0];
                    xrwe = 1;
                    xsc  = (op == 1);
                end else if (op == 8)  begin xasrc = 1; xrwe = 1; end
                else if (op == 9)  begin xrd = 1; pch = 1; end
                else if (op == 10) xwr = 1;
                else if (op == 11) xbz = 1;
                else if (op == 12) xbnz = 1;
                else if (op == 13) xbabs = 1;
                else if (op == 14) begin xrsel = 1; xrwe = 1; xbabs = 1; end
                else if (fc)       pch = 1;
                else               begin xlut = 1; xbabs = 1; end
            end
            default: ;
        endcase
        return {dps, pch, xbnz, xbz, xbabs, xrwe, xrsel, xlut, xm2r, xasrc, xsc, xrd, xwr, xaop, bsy, hlt};
    endfunction

    assign exp_o     = exp_ctrl(m_ph, opcode, fcode);
    assign exp_cyc16 = (m_cyc > 65535) ? 16'hFFFF : 16'(m_cyc);
    assign exp_ins16 = (m_ins > 65535) ? 16'hFFFF : 16'(m_ins);
    assign exp_cyc4  = (m_cyc > 15) ? 4'hF : 4'(m_cyc);
    assign exp_ins4  = (m_ins > 15) ? 4'hF : 4'(m_ins);

    // Phase-level reference model
    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            m_ph  <= P_IDLE;
            m_cyc <= 0;
            m_ins <= 0;
        end else begin
            case (m_ph)
                P_IDLE, P_HALTED: if (start) begin m_ph <= P_INIT; m_cyc <= 0; m_ins <= 0; end
                P_INIT: m_ph <= P_RUN;
                P_LOAD: begin m_cyc <= m_cyc + 1; m_ins <= m_ins + 1; m_ph <= P_RUN; end
                P_RUN: begin
                    m_cyc <= m_cyc + 1;
                    if (opcode != 9 && !(opcode == 15 && fcode)) m_ins <= m_ins + 1;
                    if ((opcode == 15 && fcode) || done_in) m_ph <= P_HALTED;
                    else if (opcode == 9) m_ph <= P_LOAD;
                end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    task automatic go();
        @(posedge CLK);
        #1;
    endtask

    task automatic ensure_run();
        done_in = 0;
        if (m_ph == P_LOAD) begin opcode = 0; go(); end
        if (m_ph == P_IDLE || m_ph == P_HALTED) begin start = 1; go(); start = 0; end
        if (m_ph == P_INIT) go();
    endtask

    task automatic do_reset();
        reset = 1;
        go();
        reset = 0;
        go();
    endtask

    task automatic test_reset();
        reset = 1;
        go();
        go();
        @(negedge CLK);
        n_cmp++;
        if (obs !== RST_OBS) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs, RST_OBS);
        end
        n_cmp++;
        if (cyc16 !== 16'd0 || ins16 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", cyc16, ins16);
        end
        reset = 0;
        go();
    endtask

    task automatic test_start();
        start = 1;
        opcode = 0;
        fcode = 0;
        @(negedge CLK);
        n_cmp++;
        if (dp_start !== 1'b0 || pc_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_before_start: dp_start=%b pc_hold=%b want 0/1", dp_start, pc_hold);
        end
        go();
        start = 0;
        @(negedge CLK);
        n_cmp++;
        if (obs !== exp_o || dp_start !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL init_cycle: got %h want %h", obs, exp_o);
        end
        go();
        @(negedge CLK);
        n_cmp++;
        if (dp_start !== 1'b0 || busy !== 1'b1 || rwe !== 1'b1 || aop !== 3'd0) begin
            n_fail++;
            $display("FAIL first_run: dp=%b busy=%b rwe=%b aop=%0d want 0/1/1/0", dp_start, busy, rwe, aop);
        end
    endtask

    task automatic test_decode_sweep();
        for (int k = 0; k < 32; k++) begin
            ensure_run();
            opcode = 4'(k >> 1);
            fcode = 1'(k);
            @(negedge CLK);
            n_cmp++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL decode_op%0d_f%0d: got %h want %h", opcode, fcode, obs, exp_o);
            end
            if (opcode == 1) begin
                n_cmp++;
                if (sc !== 1'b1 || aop !== 3'd1) begin
                    n_fail++;
                    $display("FAIL spot_sub: sc=%b aop=%0d want 1/1", sc, aop);
                end
            end
            if (opcode == 14) begin
                n_cmp++;
                if ({rsel, rwe, babs} !== 3'b111) begin
                    n_fail++;
                    $display("FAIL spot_call: got %b want 111", {rsel, rwe, babs});
                end
            end
            go();
        end
    endtask

    task automatic test_load_stall();
        int c0, i0;
        ensure_run();
        c0 = m_cyc;
        i0 = m_ins;
        opcode = 9;
        fcode = 0;
        @(negedge CLK);
        n_cmp++;
        if (rd !== 1'b1 || pc_hold !== 1'b1 || rwe !== 1'b0) begin
            n_fail++;
            $display("FAIL load_c1: rd=%b hold=%b rwe=%b want 1/1/0", rd, pc_hold, rwe);
        end
        go();
        opcode = 4'($urandom_range(0, 15));
        @(negedge CLK);
        n_cmp++;
        if (m2r !== 1'b1 || rwe !== 1'b1 || pc_hold !== 1'b0 || rd !== 1'b1) begin
            n_fail++;
            $display("FAIL load_c2: m2r=%b rwe=%b hold=%b rd=%b want 1/1/0/1", m2r, rwe, pc_hold, rd);
        end
        go();
        n_cmp++;
        if (32'(cyc16) !== c0 + 2 || 32'(ins16) !== i0 + 1) begin
            n_fail++;
            $display("FAIL load_counts: got %0d/%0d want %0d/%0d", cyc16, ins16, c0 + 2, i0 + 1);
        end
    endtask

    task automatic test_halt_rerun();
        do_reset();
        ensure_run();
        for (int i = 0; i < 5; i++) begin
            opcode = 4'($urandom_range(0, 7));
            go();
        end
        opcode = 15;
        fcode = 1;
        @(negedge CLK);
        n_cmp++;
        if (obs !== exp_o || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_decode: got %h want %h", obs, exp_o);
        end
        go();
        fcode = 0;
        opcode = 0;
        @(negedge CLK);
        n_cmp++;
        if (halted !== 1'b1 || ins16 !== 16'd5 || cyc16 !== 16'd6) begin
            n_fail++;
            $display("FAIL halted_counts: halted=%b ins=%0d cyc=%0d want 1/5/6", halted, ins16, cyc16);
        end
        go();
        n_cmp++;
        if (ins16 !== 16'd5 || cyc16 !== 16'd6) begin
            n_fail++;
            $display("FAIL halted_freeze: ins=%0d cyc=%0d want 5/6", ins16, cyc16);
        end
        start = 1;
        go();
        start = 0;
        @(negedge CLK);
        n_cmp++;
        if (dp_start !== 1'b1 || cyc16 !== 16'd0 || ins16 !== 16'd0) begin
            n_fail++;
            $display("FAIL rerun_clear: dp=%b cyc=%0d ins=%0d want 1/0/0", dp_start, cyc16, ins16);
        end
        go();
    endtask

    task automatic test_done_on_load();
        int i0;
        ensure_run();
        i0 = m_ins;
        opcode = 9;
        done_in = 1;
        @(negedge CLK);
        n_cmp++;
        if (rd !== 1'b1 || obs !== exp_o) begin
            n_fail++;
            $display("FAIL done_load_c1: got %h want %h", obs, exp_o);
        end
        go();
        done_in = 0;
        @(negedge CLK);
        n_cmp++;
        if (halted !== 1'b1 || m2r !== 1'b0 || 32'(ins16) !== i0) begin
            n_fail++;
            $display("FAIL done_load_exit: halted=%b m2r=%b ins=%0d want 1/0/%0d", halted, m2r, ins16, i0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ensure_run();
        opcode = 0;
        fcode = 0;
        for (int i = 0; i < 20; i++) go();
        n_cmp++;
        if (cyc4 !== 4'd15 || ins4 !== 4'd15) begin
            n_fail++;
            $display("FAIL sat4: cyc=%0d ins=%0d want 15/15", cyc4, ins4);
        end
        n_cmp++;
        if (cyc16 !== 16'd20) begin
            n_fail++;
            $display("FAIL nosat16: cyc=%0d want 20", cyc16);
        end
    endtask

    task automatic test_reset_midrun();
        ensure_run();
        opcode = 3;
        go();
        go();
        #2;
        reset = 1;
        #1;
        n_cmp++;
        if (obs !== RST_OBS || cyc16 !== 16'd0 || ins16 !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h cyc=%0d ins=%0d want %h/0/0", obs, cyc16, ins16, RST_OBS);
        end
        @(negedge CLK);
        reset = 0;
        go();
        @(negedge CLK);
        n_cmp++;
        if (obs !== exp_o || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h want %h", obs, exp_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            opcode  = 4'($urandom_range(0, 15));
            fcode   = 1'($urandom_range(0, 1));
            start   = 1'($urandom_range(0, 1));
            done_in = ($urandom_range(0, 24) == 0);
            @(negedge CLK);
            n_cmp++;
            if (obs !== exp_o || obs4 !== exp_o || cyc16 !== exp_cyc16 || ins16 !== exp_ins16 ||
                cyc4 !== exp_cyc4 || ins4 !== exp_ins4) begin
                n_fail++;
                $display("FAIL random_%0d: out %h/%h want %h cnt %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                         i, obs, obs4, exp_o, cyc16, ins16, cyc4, ins4, exp_cyc16, exp_ins16, exp_cyc4, exp_ins4);
            end
            go();
        end
        start = 0;
        done_in = 0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_decode_sweep();
        test_load_stall();
        test_halt_rerun();
        test_done_on_load();
        test_saturation();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
